hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU.
- Drives the hold and flush inputs of the pipeline register buffers (PC, IF/ID, ID/EX, EX/MEM).
- Handles three cases: load-use hazards, taken-branch redirects, and multi-cycle mul/div occupancy of EX.
- Also latches halt requests and freezes the pipeline.
- Provides a saturating stall-cycle counter for performance debug.

Parameters:
REG_W, 4, register-address width (16 architectural registers; register 0 is hardwired zero)
MC_CYCLES, 4, total cycles a mul/div occupies EX (legal range 1..8)
CNT_W, 16, width of the stall performance counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low
id_rs1  input  REG_W  source register 1 of the instruction in ID
id_rs2  input  REG_W  source register 2 of the instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
id_mc_start  input  1  ID instruction is a multi-cycle mul/div
ex_rd  input  REG_W  destination register of the instruction in EX
ex_reg_write  input  1  EX instruction writes ex_rd
ex_mem_read  input  1  EX instruction is a load
ex_branch_taken  input  1  branch resolved taken in EX this cycle
halt_req  input  1  halt/exception request, single-cycle pulse or level
pc_hold  output  1  PC register keeps its value
ifid_hold  output  1  IF/ID buffer holds
idex_hold  output  1  ID/EX buffer holds
exmem_hold  output  1  EX/MEM buffer holds
ifid_flush  output  1  bubble into IF/ID
idex_flush  output  1  bubble into ID/EX
exmem_flush  output  1  bubble into EX/MEM
mc_busy  output  1  multi-cycle op occupying EX
halted  output  1  pipeline frozen
stall_count  output  CNT_W  cycles with pc_hold=1 outside HALT, saturating

Behaviour:
- Reset (asynchronous, active-low): state=RUN, mc counter=0, halt_pending=0, stall_count=0. All hold/flush/mc_busy/halted outputs are forced 0 while reset is low.
- State machine: RUN, MC_WAIT, HALT. Hold/flush outputs are combinational from state plus current inputs; state, counter and pending flag are registered.
- Load-use hazard (RUN only) is true when all of the following hold:
  - ex_mem_read=1 and ex_reg_write=1 and ex_rd!=0;
  - (id_rs1_used and id_rs1==ex_rd) or (id_rs2_used and id_rs2==ex_rd).
- Load-use response, same cycle: pc_hold=1, ifid_hold=1, idex_flush=1. Exactly one bubble is inserted; the hazard clears naturally next cycle.
- Branch taken (RUN only): ifid_flush=1 and idex_flush=1 in the same cycle.
  - Branch beats load-use: pc_hold=0, ifid_hold=0 so the PC accepts the target.
  - id_mc_start is ignored in that cycle (the instruction is squashed).
- Multi-cycle start (RUN only): id_mc_start=1 with no branch and no load-use.
  - If MC_CYCLES=1, no state change.
  - Otherwise, at the next edge: state goes to MC_WAIT, counter loads MC_CYCLES-2.
- MC_WAIT lasts exactly MC_CYCLES-1 cycles.
  - Outputs each cycle: pc_hold=ifid_hold=idex_hold=1, exmem_flush=1, mc_busy=1.
  - Counter decrements each cycle; at the edge where counter==0 the state returns to RUN.
  - ex_branch_taken, load-use and id_mc_start are ignored in MC_WAIT.
- Halt: halt_req=1 in any state sets halt_pending at the edge.
  - From RUN with halt_pending=1 (or halt_req=1 that cycle): go to HALT at the next edge.
  - From MC_WAIT: finish the countdown, return to RUN, then go to HALT at the following edge.
- HALT outputs: pc_hold=ifid_hold=idex_hold=exmem_hold=1, halted=1, all flushes 0. HALT exits only via reset.
- stall_count increments at each edge where pc_hold=1 and state!=HALT. It saturates at 2^CNT_W-1 and never wraps.
- Reset mid-MC_WAIT aborts immediately to RUN with all outputs 0; the counter and halt_pending are cleared.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_rs2_used=1 for 1 cycle -> pc_hold=ifid_hold=idex_flush=1 that cycle only; stall_count 0->1.
- ex_rd=0 with the same load/match, or id_rs2_used=0 -> no hold/flush asserted; stall_count unchanged.
- Branch with simultaneous load-use: ex_branch_taken=1 plus a load-use match -> ifid_flush=idex_flush=1, pc_hold=0, ifid_hold=0.
- Mul with MC_CYCLES=4: id_mc_start pulse in RUN -> mc_busy, holds and exmem_flush high for exactly 3 cycles, then RUN; stall_count=3. Repeat with MC_CYCLES=1 -> no stall.
- Halt during MC_WAIT: halt_req pulse on the 2nd MC_WAIT cycle -> countdown completes, one RUN cycle follows, then halted=1 with all holds=1 held indefinitely; stall_count frozen.
- Reset asserted mid-MC_WAIT -> all outputs 0 immediately; after release a new id_mc_start gives a full 3-cycle stall. Separately, force stall_count to 0xFFFF -> further stalls keep it at 0xFFFF.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard/stall sequencer.
// master = pipeline side (hazard sources), slave = sequencer (hold/flush sink).
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             id_mc_start;
    logic [REG_W-1:0] ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             halt_req;

    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_hold;
    logic             exmem_hold;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             mc_busy;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    // Encoded sequencer state: 0 = RUN, 1 = MC_WAIT, 2 = HALT.
    logic [1:0]       state_dbg;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_mc_start,
        output ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken, halt_req,
        input  pc_hold, ifid_hold, idex_hold, exmem_hold,
        input  ifid_flush, idex_flush, exmem_flush,
        input  mc_busy, halted, stall_count, state_dbg
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_mc_start,
        input  ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken, halt_req,
        output pc_hold, ifid_hold, idex_hold, exmem_hold,
        output ifid_flush, idex_flush, exmem_flush,
        output mc_busy, halted, stall_count, state_dbg
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use bubbles, branch squash, mul/div EX occupancy,
// halt freeze, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int REG_W     = 4,
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input logic               clock,
    input logic               reset,
    hazard_stall_ctrl_if.slave bus
);
    localparam int MC_W = 3;
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'((MC_CYCLES >= 2) ? (MC_CYCLES - 2) : 0);
    localparam bit MC_MULTI = (MC_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic             halt_pending_q, halt_pending_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic pc_hold_c, ifid_hold_c, idex_hold_c, exmem_hold_c;
    logic ifid_flush_c, idex_flush_c, exmem_flush_c, mc_busy_c, halted_c;

    always_comb begin
        load_use = bus.ex_mem_read && bus.ex_reg_write && (bus.ex_rd != '0) &&
                   ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                    (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            mc_cnt_q       <= '0;
            halt_pending_q <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            mc_cnt_q       <= mc_cnt_d;
            halt_pending_q <= halt_pending_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mc_cnt_d       = mc_cnt_q;
        halt_pending_d = halt_pending_q | bus.halt_req;
        pc_hold_c      = 1'b0;
        ifid_hold_c    = 1'b0;
        idex_hold_c    = 1'b0;
        exmem_hold_c   = 1'b0;
        ifid_flush_c   = 1'b0;
        idex_flush_c   = 1'b0;
        exmem_flush_c  = 1'b0;
        mc_busy_c      = 1'b0;
        halted_c       = 1'b0;

        case (state_q)
            ST_RUN: begin
                // A taken branch squashes ID, so it wins over load-use and mc start.
                if (bus.ex_branch_taken) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_hold_c    = 1'b1;
                    ifid_hold_c  = 1'b1;
                    idex_flush_c = 1'b1;
                end
                if (halt_pending_q || bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (MC_MULTI && bus.id_mc_start &&
                             !bus.ex_branch_taken && !load_use) begin
                    state_d  = ST_MC_WAIT;
                    mc_cnt_d = MC_LOAD;
                end
            end
            ST_MC_WAIT: begin
                pc_hold_c     = 1'b1;
                ifid_hold_c   = 1'b1;
                idex_hold_c   = 1'b1;
                exmem_flush_c = 1'b1;
                mc_busy_c     = 1'b1;
                if (mc_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    mc_cnt_d = mc_cnt_q - 1'b1;
                end
            end
            ST_HALT: begin
                pc_hold_c    = 1'b1;
                ifid_hold_c  = 1'b1;
                idex_hold_c  = 1'b1;
                exmem_hold_c = 1'b1;
                halted_c     = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (pc_hold_c && (state_q != ST_HALT) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Gating by reset keeps the combinational RUN decode quiet while held in reset.
    assign bus.pc_hold     = pc_hold_c     & reset;
    assign bus.ifid_hold   = ifid_hold_c   & reset;
    assign bus.idex_hold   = idex_hold_c   & reset;
    assign bus.exmem_hold  = exmem_hold_c  & reset;
    assign bus.ifid_flush  = ifid_flush_c  & reset;
    assign bus.idex_flush  = idex_flush_c  & reset;
    assign bus.exmem_flush = exmem_flush_c & reset;
    assign bus.mc_busy     = mc_busy_c     & reset;
    assign bus.halted      = halted_c      & reset;
    assign bus.stall_count = stall_cnt_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: main instance plus MC_CYCLES=1 and
// 4-bit-counter instances sharing the same stimulus.
module tb_hazard_stall_ctrl;
    logic clock = 1'b0;
    logic reset;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    hazard_stall_ctrl_if #(.REG_W(4), .CNT_W(16)) bus0 ();
    hazard_stall_ctrl_if #(.REG_W(4), .CNT_W(16)) bus1 ();
    hazard_stall_ctrl_if #(.REG_W(4), .CNT_W(4))  bus2 ();

    hazard_stall_ctrl #(.REG_W(4), .MC_CYCLES(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .bus(bus0));
    hazard_stall_ctrl #(.REG_W(4), .MC_CYCLES(1), .CNT_W(16)) dut_mc1 (
        .clock(clock), .reset(reset), .bus(bus1));
    hazard_stall_ctrl #(.REG_W(4), .MC_CYCLES(4), .CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .bus(bus2));

    assign bus1.id_rs1          = bus0.id_rs1;
    assign bus1.id_rs2          = bus0.id_rs2;
    assign bus1.id_rs1_used     = bus0.id_rs1_used;
    assign bus1.id_rs2_used     = bus0.id_rs2_used;
    assign bus1.id_mc_start     = bus0.id_mc_start;
    assign bus1.ex_rd           = bus0.ex_rd;
    assign bus1.ex_reg_write    = bus0.ex_reg_write;
    assign bus1.ex_mem_read     = bus0.ex_mem_read;
    assign bus1.ex_branch_taken = bus0.ex_branch_taken;
    assign bus1.halt_req        = bus0.halt_req;
    assign bus2.id_rs1          = bus0.id_rs1;
    assign bus2.id_rs2          = bus0.id_rs2;
    assign bus2.id_rs1_used     = bus0.id_rs1_used;
    assign bus2.id_rs2_used     = bus0.id_rs2_used;
    assign bus2.id_mc_start     = bus0.id_mc_start;
    assign bus2.ex_rd           = bus0.ex_rd;
    assign bus2.ex_reg_write    = bus0.ex_reg_write;
    assign bus2.ex_mem_read     = bus0.ex_mem_read;
    assign bus2.ex_branch_taken = bus0.ex_branch_taken;
    assign bus2.halt_req        = bus0.halt_req;

    // {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, exmem_flush, mc_busy, halted}
    wire [8:0] outs0 = {bus0.pc_hold, bus0.ifid_hold, bus0.idex_hold, bus0.exmem_hold,
                        bus0.ifid_flush, bus0.idex_flush, bus0.exmem_flush, bus0.mc_busy, bus0.halted};
    wire [8:0] outs1 = {bus1.pc_hold, bus1.ifid_hold, bus1.idex_hold, bus1.exmem_hold,
                        bus1.ifid_flush, bus1.idex_flush, bus1.exmem_flush, bus1.mc_busy, bus1.halted};

    localparam logic [8:0] O_NONE = 9'b000000000;
    localparam logic [8:0] O_LU   = 9'b110001000;
    localparam logic [8:0] O_BR   = 9'b000011000;
    localparam logic [8:0] O_MC   = 9'b111000110;
    localparam logic [8:0] O_HALT = 9'b111100001;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus0.id_rs1          = '0;
        bus0.id_rs2          = '0;
        bus0.id_rs1_used     = 1'b0;
        bus0.id_rs2_used     = 1'b0;
        bus0.id_mc_start     = 1'b0;
        bus0.ex_rd           = '0;
        bus0.ex_reg_write    = 1'b0;
        bus0.ex_mem_read     = 1'b0;
        bus0.ex_branch_taken = 1'b0;
        bus0.halt_req        = 1'b0;
    endtask

    task automatic set_load(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                            input logic u1, input logic u2);
        bus0.ex_mem_read  = 1'b1;
        bus0.ex_reg_write = 1'b1;
        bus0.ex_rd        = rd;
        bus0.id_rs1       = rs1;
        bus0.id_rs2       = rs2;
        bus0.id_rs1_used  = u1;
        bus0.id_rs2_used  = u2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        set_load(4'd5, 4'd0, 4'd5, 1'b0, 1'b1);
        #3;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL reset_outs got=%b exp=%b", outs0, O_NONE); end
        tick();
        n_cmp++;
        if (bus0.stall_count !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", bus0.stall_count); end
        n_cmp++;
        if (bus0.state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", bus0.state_dbg); end
        idle();
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        set_load(4'd5, 4'd0, 4'd5, 1'b0, 1'b1);
        #3;
        n_cmp++;
        if (outs0 !== O_LU) begin n_err++; $display("FAIL lu_outs got=%b exp=%b", outs0, O_LU); end
        tick();
        idle();
        #3;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL lu_clear got=%b exp=%b", outs0, O_NONE); end
        n_cmp++;
        if (bus0.stall_count !== 16'd1) begin n_err++; $display("FAIL lu_cnt got=%0d exp=1", bus0.stall_count); end
        tick();
    endtask

    task automatic test_no_hazard();
        set_load(4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        #3;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL rd0_outs got=%b exp=%b", outs0, O_NONE); end
        tick();
        set_load(4'd5, 4'd0, 4'd5, 1'b0, 1'b0);
        #3;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL unused_outs got=%b exp=%b", outs0, O_NONE); end
        tick();
        set_load(4'd7, 4'd7, 4'd3, 1'b1, 1'b1);
        bus0.ex_mem_read = 1'b0;
        #3;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL noload_outs got=%b exp=%b", outs0, O_NONE); end
        n_cmp++;
        if (bus0.stall_count !== 16'd1) begin n_err++; $display("FAIL nohaz_cnt got=%0d exp=1", bus0.stall_count); end
        tick();
        set_load(4'd7, 4'd7, 4'd3, 1'b1, 1'b1);
        #3;
        n_cmp++;
        if (outs0 !== O_LU) begin n_err++; $display("FAIL rs1_lu_outs got=%b exp=%b", outs0, O_LU); end
        tick();
        idle();
        n_cmp++;
        if (bus0.stall_count !== 16'd2) begin n_err++; $display("FAIL rs1_lu_cnt got=%0d exp=2", bus0.stall_count); end
    endtask

    task automatic test_branch();
        set_load(4'd5, 4'd5, 4'd0, 1'b1, 1'b0);
        bus0.ex_branch_taken = 1'b1;
        #3;
        n_cmp++;
        if (outs0 !== O_BR) begin n_err++; $display("FAIL br_lu_outs got=%b exp=%b", outs0, O_BR); end
        tick();
        idle();
        bus0.ex_branch_taken = 1'b1;
        bus0.id_mc_start     = 1'b1;
        #3;
        n_cmp++;
        if (outs0 !== O_BR) begin n_err++; $display("FAIL br_mc_outs got=%b exp=%b", outs0, O_BR); end
        tick();
        idle();
        #3;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL br_mc_squash got=%b exp=%b", outs0, O_NONE); end
        n_cmp++;
        if (bus0.stall_count !== 16'd2) begin n_err++; $display("FAIL br_cnt got=%0d exp=2", bus0.stall_count); end
        tick();
    endtask

    task automatic test_multicycle();
        bus0.id_mc_start = 1'b1;
        #3;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL mc_start_outs got=%b exp=%b", outs0, O_NONE); end
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                set_load(4'd5, 4'd5, 4'd5, 1'b1, 1'b1);
                bus0.ex_branch_taken = 1'b1;
                bus0.id_mc_start     = 1'b1;
            end else begin
                idle();
            end
            #3;
            n_cmp++;
            if (outs0 !== O_MC) begin n_err++; $display("FAIL mc_wait_outs cyc=%0d got=%b exp=%b", i, outs0, O_MC); end
            if (i != 1) begin
                n_cmp++;
                if (outs1 !== O_NONE) begin n_err++; $display("FAIL mc1_outs cyc=%0d got=%b exp=%b", i, outs1, O_NONE); end
            end
            tick();
        end
        idle();
        #3;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL mc_done_outs got=%b exp=%b", outs0, O_NONE); end
        n_cmp++;
        if (bus0.state_dbg !== 2'd0) begin n_err++; $display("FAIL mc_done_state got=%0d exp=0", bus0.state_dbg); end
        n_cmp++;
        if (bus0.stall_count !== 16'd5) begin n_err++; $display("FAIL mc_cnt got=%0d exp=5", bus0.stall_count); end
        n_cmp++;
        if (bus1.stall_count !== 16'd2) begin n_err++; $display("FAIL mc1_cnt got=%0d exp=2", bus1.stall_count); end
        tick();
    endtask

    task automatic test_saturation();
        set_load(4'd9, 4'd9, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        idle();
        #3;
        n_cmp++;
        if (bus2.stall_count !== 4'hF) begin n_err++; $display("FAIL sat_cnt got=%0d exp=15", bus2.stall_count); end
        n_cmp++;
        if (bus0.stall_count !== 16'd19) begin n_err++; $display("FAIL wide_cnt got=%0d exp=19", bus0.stall_count); end
        n_cmp++;
        if (bus1.stall_count !== 16'd16) begin n_err++; $display("FAIL mc1_lu_cnt got=%0d exp=16", bus1.stall_count); end
        tick();
        set_load(4'd9, 4'd9, 4'd0, 1'b1, 1'b0);
        tick();
        idle();
        n_cmp++;
        if (bus2.stall_count !== 4'hF) begin n_err++; $display("FAIL sat_hold got=%0d exp=15", bus2.stall_count); end
    endtask

    task automatic test_reset_mid_mc();
        bus0.id_mc_start = 1'b1;
        tick();
        idle();
        #3;
        n_cmp++;
        if (outs0 !== O_MC) begin n_err++; $display("FAIL rst_pre_outs got=%b exp=%b", outs0, O_MC); end
        reset = 1'b0;
        set_load(4'd5, 4'd0, 4'd5, 1'b0, 1'b1);
        #1;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL rst_mid_outs got=%b exp=%b", outs0, O_NONE); end
        n_cmp++;
        if (bus0.stall_count !== 16'd0) begin n_err++; $display("FAIL rst_mid_cnt got=%0d exp=0", bus0.stall_count); end
        n_cmp++;
        if (bus0.state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_mid_state got=%0d exp=0", bus0.state_dbg); end
        idle();
        tick();
        @(negedge clock);
        reset = 1'b1;
        tick();
        bus0.id_mc_start = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #3;
            n_cmp++;
            if (outs0 !== O_MC) begin n_err++; $display("FAIL rst_mc_outs cyc=%0d got=%b exp=%b", i, outs0, O_MC); end
            tick();
        end
        #3;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL rst_mc_done got=%b exp=%b", outs0, O_NONE); end
        n_cmp++;
        if (bus0.stall_count !== 16'd3) begin n_err++; $display("FAIL rst_mc_cnt got=%0d exp=3", bus0.stall_count); end
        tick();
    endtask

    task automatic test_halt_in_mc();
        bus0.id_mc_start = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            bus0.halt_req = (i == 1);
            #3;
            n_cmp++;
            if (outs0 !== O_MC) begin n_err++; $display("FAIL halt_mc_outs cyc=%0d got=%b exp=%b", i, outs0, O_MC); end
            tick();
        end
        idle();
        #3;
        n_cmp++;
        if (outs0 !== O_NONE) begin n_err++; $display("FAIL halt_run_gap got=%b exp=%b", outs0, O_NONE); end
        n_cmp++;
        if (bus0.state_dbg !== 2'd0) begin n_err++; $display("FAIL halt_run_state got=%0d exp=0", bus0.state_dbg); end
        tick();
        set_load(4'd5, 4'd5, 4'd5, 1'b1, 1'b1);
        bus0.ex_branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            n_cmp++;
            if (outs0 !== O_HALT) begin n_err++; $display("FAIL halt_outs cyc=%0d got=%b exp=%b", i, outs0, O_HALT); end
            n_cmp++;
            if (bus0.stall_count !== 16'd6) begin n_err++; $display("FAIL halt_cnt cyc=%0d got=%0d exp=6", i, bus0.stall_count); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_multicycle();
        test_saturation();
        test_reset_mid_mc();
        test_halt_in_mc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
